// File: rtl/full_stage_ctrl_data_fifo_p_pkg.sv
// Shared types for the full-connection stage input-buffer controller.
package full_stage_ctrl_data_fifo_p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ERR  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  expo;
    } float_24_8_t;

    localparam int FLOAT_24_8_W = $bits(float_24_8_t);

    function automatic int slot_addr_w(input int slot_w, input int len_w);
        return slot_w + len_w;
    endfunction

endpackage

// File: rtl/full_stage_delay_line.sv
// Fixed-latency 1-bit strobe delay with synchronous active-low clear.
module full_stage_delay_line #(
    parameter int DLY = 16
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic dout
);

    logic [DLY-1:0] sr_r;

    // Shift the strobe one stage per cycle; clr_n wipes everything in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sr_r <= '0;
        end else begin
            sr_r[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign dout = sr_r[DLY-1];

endmodule

// File: rtl/full_stage_ctrl_data_fifo_p.sv
// Input-buffer controller: loads bursts into slot RAM, sequences forward and
// error-replay reads, and produces tap addresses and delayed activity strobes.
module full_stage_ctrl_data_fifo_p
    import full_stage_ctrl_data_fifo_p_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SLOT_W  = 3,
    parameter int PRE_DLY = 16,
    parameter int OUT_DLY = 18,
    localparam int ADDR_W = slot_addr_w(SLOT_W, LEN_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cfg_length,
    input  logic [SLOT_W-1:0] cfg_depth,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              err_req,
    input  logic              err_finish,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_err,
    output logic [LEN_W:0]    tap_address,
    output logic              state_finish,
    output logic              active_pre,
    output logic              active,
    output logic [SLOT_W:0]   occupancy,
    output logic              underflow
);

    localparam logic [SLOT_W:0]   CNT_ONE  = (SLOT_W+1)'(1'b1);
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1'b1);
    localparam logic [LEN_W-1:0]  BEAT_ONE = LEN_W'(1'b1);

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s,
                                                   input logic [SLOT_W-1:0] last);
        return (s == last) ? '0 : s + SLOT_ONE;
    endfunction

    ctrl_state_e       state_r;
    logic [LEN_W-1:0]  wr_beat_r;
    logic [LEN_W-1:0]  rd_beat_r;
    logic [SLOT_W-1:0] wr_slot_r;
    logic [SLOT_W-1:0] rd_slot_r;
    logic [SLOT_W-1:0] er_slot_r;
    logic [SLOT_W:0]   occupancy_r;
    logic [SLOT_W:0]   pending_r;
    logic              underflow_r;

    logic [SLOT_W:0]   depth_cnt_s;
    logic              wr_fire_s;
    logic              slot_done_s;
    logic              release_s;
    logic              rd_last_s;
    logic              fwd_done_s;
    logic              fwd_vld_s;
    logic              clr_n_s;
    logic [SLOT_W:0]   occ_nxt_s;
    logic [SLOT_W:0]   pending_nxt_s;

    assign depth_cnt_s = {1'b0, cfg_depth} + CNT_ONE;
    assign in_rdy      = (occupancy_r != depth_cnt_s);
    assign wr_fire_s   = in_vld & in_rdy;
    assign slot_done_s = wr_fire_s && (wr_beat_r == cfg_length);
    assign release_s   = err_finish && (occupancy_r != '0);
    assign rd_last_s   = (state_r != ST_IDLE) && (rd_beat_r == cfg_length);
    assign fwd_done_s  = (state_r == ST_FWD) && rd_last_s;

    // Net slot count after this cycle's completion and release.
    always_comb begin
        occ_nxt_s = occupancy_r;
        if (slot_done_s && !release_s) begin
            occ_nxt_s = occupancy_r + CNT_ONE;
        end else if (!slot_done_s && release_s) begin
            occ_nxt_s = occupancy_r - CNT_ONE;
        end else begin
            occ_nxt_s = occupancy_r;
        end
    end

    // Slots awaiting a forward read; a same-cycle completion is included.
    always_comb begin
        pending_nxt_s = pending_r;
        if (slot_done_s && !fwd_done_s) begin
            pending_nxt_s = pending_r + CNT_ONE;
        end else if (!slot_done_s && fwd_done_s) begin
            pending_nxt_s = pending_r - CNT_ONE;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Load-side beat and slot pointers.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_beat_r <= '0;
            wr_slot_r <= '0;
        end else if (wr_fire_s) begin
            if (slot_done_s) begin
                wr_beat_r <= '0;
                wr_slot_r <= next_slot(wr_slot_r, cfg_depth);
            end else begin
                wr_beat_r <= wr_beat_r + BEAT_ONE;
            end
        end
    end

    // Slot accounting, release pointer and sticky underflow.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            occupancy_r <= '0;
            pending_r   <= '0;
            er_slot_r   <= '0;
            underflow_r <= 1'b0;
        end else begin
            occupancy_r <= occ_nxt_s;
            pending_r   <= pending_nxt_s;
            if (release_s) begin
                er_slot_r <= next_slot(er_slot_r, cfg_depth);
            end
            if (err_finish && (occupancy_r == '0)) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Read sequencer: error replay wins over forward reads when leaving IDLE.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state_r   <= ST_IDLE;
            rd_beat_r <= '0;
            rd_slot_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rd_beat_r <= '0;
                    if (err_req && (occupancy_r != '0)) begin
                        state_r <= ST_ERR;
                    end else if (pending_r != '0) begin
                        state_r <= ST_FWD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FWD: begin
                    if (rd_last_s) begin
                        rd_beat_r <= '0;
                        rd_slot_r <= next_slot(rd_slot_r, cfg_depth);
                        state_r   <= ((pending_nxt_s != '0) && !err_req) ? ST_FWD : ST_IDLE;
                    end else begin
                        rd_beat_r <= rd_beat_r + BEAT_ONE;
                    end
                end
                ST_ERR: begin
                    if (rd_last_s) begin
                        rd_beat_r <= '0;
                        state_r   <= ST_IDLE;
                    end else begin
                        rd_beat_r <= rd_beat_r + BEAT_ONE;
                    end
                end
                default: begin
                    rd_beat_r <= '0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Read address selects the replay slot during error reads.
    always_comb begin
        rd_addr = '0;
        case (state_r)
            ST_FWD:  rd_addr = {rd_slot_r, rd_beat_r};
            ST_ERR:  rd_addr = {er_slot_r, rd_beat_r};
            default: rd_addr = '0;
        endcase
    end

    assign wr_en        = wr_fire_s;
    assign wr_addr      = {wr_slot_r, wr_beat_r};
    assign wr_data      = in_data;
    assign rd_en        = (state_r != ST_IDLE);
    assign rd_err       = (state_r == ST_ERR);
    assign tap_address  = (state_r == ST_IDLE) ? '0 : {1'b0, rd_beat_r};
    assign state_finish = rd_last_s;
    assign occupancy    = occupancy_r;
    assign underflow    = underflow_r;
    assign fwd_vld_s    = rd_en & ~rd_err;
    assign clr_n_s      = reset & ~flush;

    full_stage_delay_line #(.DLY(PRE_DLY)) u_dly_pre (
        .clk   (clk),
        .clr_n (clr_n_s),
        .din   (fwd_vld_s),
        .dout  (active_pre)
    );

    full_stage_delay_line #(.DLY(OUT_DLY)) u_dly_out (
        .clk   (clk),
        .clr_n (clr_n_s),
        .din   (fwd_vld_s),
        .dout  (active)
    );

endmodule

// File: tb/tb_full_stage_ctrl_data_fifo_p.sv
// Randomised bench for the stage input-buffer controller against a counter/queue model.
module tb_full_stage_ctrl_data_fifo_p;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SLOT_W  = 3;
    localparam int PRE_DLY = 16;
    localparam int OUT_DLY = 18;
    localparam int ADDR_W  = SLOT_W + LEN_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [LEN_W-1:0]  cfg_length;
    logic [SLOT_W-1:0] cfg_depth;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_vld;
    logic              in_rdy;
    logic              err_req;
    logic              err_finish;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;
    logic [LEN_W:0]    tap_address;
    logic              state_finish;
    logic              active_pre;
    logic              active;
    logic [SLOT_W:0]   occupancy;
    logic              underflow;

    always #5 clk = ~clk;

    full_stage_ctrl_data_fifo_p #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .SLOT_W(SLOT_W),
        .PRE_DLY(PRE_DLY), .OUT_DLY(OUT_DLY)
    ) dut (
        .clk(clk), .reset(reset), .cfg_length(cfg_length), .cfg_depth(cfg_depth),
        .flush(flush), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .err_req(err_req), .err_finish(err_finish), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_err(rd_err),
        .tap_address(tap_address), .state_finish(state_finish), .active_pre(active_pre),
        .active(active), .occupancy(occupancy), .underflow(underflow)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: plain counters for slots, a mode number for the reader and a
    // per-cycle history of forward-read activity for the strobe delays.
    int m_wr_beat, m_wr_slot, m_occ, m_pend, m_er_slot, m_rd_slot, m_rd_beat, m_mode, m_uf;
    int cyc = 0;
    bit hist [64];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_clear();
        m_wr_beat = 0; m_wr_slot = 0; m_occ = 0; m_pend = 0;
        m_er_slot = 0; m_rd_slot = 0; m_rd_beat = 0; m_mode = 0; m_uf = 0;
        for (int i = 0; i < 64; i++) hist[i] = 1'b0;
    endtask

    task automatic check_all();
        int len, dep, slot;
        bit e_rdy;
        len = int'(cfg_length);
        dep = int'(cfg_depth);
        e_rdy = (m_occ != dep + 1);
        slot = (m_mode == 2) ? m_er_slot : m_rd_slot;
        chk("in_rdy", in_rdy, e_rdy);
        chk("wr_en", wr_en, in_vld && e_rdy);
        chk("wr_addr", wr_addr, m_wr_slot * (1 << LEN_W) + m_wr_beat);
        chk("wr_data", wr_data, in_data);
        chk("rd_en", rd_en, m_mode != 0);
        chk("rd_err", rd_err, m_mode == 2);
        chk("rd_addr", rd_addr, (m_mode == 0) ? 0 : slot * (1 << LEN_W) + m_rd_beat);
        chk("tap_address", tap_address, (m_mode == 0) ? 0 : m_rd_beat);
        chk("state_finish", state_finish, (m_mode != 0) && (m_rd_beat == len));
        chk("active_pre", active_pre, (cyc >= PRE_DLY) ? hist[(cyc - PRE_DLY) % 64] : 1'b0);
        chk("active", active, (cyc >= OUT_DLY) ? hist[(cyc - OUT_DLY) % 64] : 1'b0);
        chk("occupancy", occupancy, m_occ);
        chk("underflow", underflow, m_uf);
    endtask

    task automatic model_update();
        int len, dep, pend_n, old_occ;
        bit clr, wr, done, rel;
        len = int'(cfg_length);
        dep = int'(cfg_depth);
        clr = !reset || flush;
        hist[cyc % 64] = !clr && (m_mode == 1);
        cyc++;
        if (clr) begin
            model_clear();
            return;
        end
        old_occ = m_occ;
        wr   = in_vld && (m_occ != dep + 1);
        done = wr && (m_wr_beat == len);
        rel  = err_finish && (m_occ != 0);
        if (err_finish && m_occ == 0) m_uf = 1;
        if (wr) begin
            if (done) begin
                m_wr_beat = 0;
                m_wr_slot = (m_wr_slot + 1) % (dep + 1);
            end else begin
                m_wr_beat++;
            end
        end
        m_occ = m_occ + int'(done) - int'(rel);
        if (rel) m_er_slot = (m_er_slot + 1) % (dep + 1);
        pend_n = m_pend + int'(done);
        if (m_mode == 0) begin
            if (err_req && old_occ > 0) m_mode = 2;
            else if (m_pend > 0) m_mode = 1;
        end else if (m_rd_beat == len) begin
            m_rd_beat = 0;
            if (m_mode == 1) begin
                m_rd_slot = (m_rd_slot + 1) % (dep + 1);
                pend_n--;
                m_mode = (pend_n > 0 && !err_req) ? 1 : 0;
            end else begin
                m_mode = 0;
            end
        end else begin
            m_rd_beat++;
        end
        m_pend = pend_n;
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
        in_data = $urandom;
    endtask

    task automatic do_reset(input int len, input int dep);
        cfg_length = LEN_W'(len);
        cfg_depth  = SLOT_W'(dep);
        reset = 1'b0; flush = 1'b0; in_vld = 1'b0; err_req = 1'b0; err_finish = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, first_act, first_pre, nrd, w;
        int raddr [16];
        bit rflag [16];
        bit rerr [16];

        reset = 1'b0; flush = 1'b0; in_vld = 1'b0; err_req = 1'b0; err_finish = 1'b0;
        in_data = '0; cfg_length = 4'd3; cfg_depth = 3'd1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Two 4-beat bursts then back-to-back forward reads.
        do_reset(3, 1);
        chk("lit_rst_occ", occupancy, 0);
        chk("lit_rst_in_rdy", in_rdy, 1);
        chk("lit_rst_rd_en", rd_en, 0);
        first_rd = -1; first_act = -1; first_pre = -1; nrd = 0;
        for (int t = 0; t < 40; t++) begin
            in_vld = (t < 8);
            #1;
            if (t < 8) chk("lit_wr_addr", wr_addr, (t < 4) ? t : 12 + t);
            if (t == 4) chk("lit_occ_1", occupancy, 1);
            if (t == 8) begin
                chk("lit_occ_2", occupancy, 2);
                chk("lit_in_rdy_full", in_rdy, 0);
            end
            if (rd_en && nrd < 16) begin
                if (first_rd < 0) first_rd = t;
                raddr[nrd] = int'(rd_addr); rflag[nrd] = state_finish; nrd++;
            end
            if (active && first_act < 0) first_act = t;
            if (active_pre && first_pre < 0) first_pre = t;
            step();
        end
        chk("lit_fwd_count", nrd, 8);
        for (int k = 0; k < 8; k++) begin
            chk("lit_fwd_addr", raddr[k], (k < 4) ? k : 12 + k);
            chk("lit_fwd_finish", rflag[k], (k == 3) || (k == 7));
        end
        chk("lit_active_lat", first_act - first_rd, 18);
        chk("lit_active_pre_lat", first_pre - first_rd, 16);

        // Error replay takes precedence, then forward reads resume.
        do_reset(3, 1);
        err_req = 1'b1; nrd = 0;
        for (int t = 0; t < 30; t++) begin
            in_vld = (t < 8);
            if (t == 6) err_req = 1'b0;
            #1;
            if (rd_en && nrd < 5) begin
                raddr[nrd] = int'(rd_addr); rerr[nrd] = rd_err; nrd++;
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk("lit_err_addr", raddr[k], k);
            chk("lit_err_flag", rerr[k], 1);
        end
        chk("lit_fwd_after_err_addr", raddr[4], 0);
        chk("lit_fwd_after_err_flag", rerr[4], 0);
        err_finish = 1'b1; step(); err_finish = 1'b0;
        chk("lit_release_occ", occupancy, 1);
        err_req = 1'b1; w = 0;
        while (!rd_en && w < 5) begin step(); w++; end
        chk("lit_err_wait", rd_en, 1);
        chk("lit_er_slot_addr", rd_addr, 16);
        err_req = 1'b0;
        repeat (8) step();

        // Completion and release in the same cycle leave occupancy unchanged.
        do_reset(3, 1);
        for (int t = 0; t < 12; t++) begin in_vld = (t < 4); step(); end
        in_vld = 1'b1;
        repeat (3) step();
        err_finish = 1'b1;
        #1 chk("lit_same_rdy_before", in_rdy, 1);
        step();
        in_vld = 1'b0; err_finish = 1'b0;
        chk("lit_same_occ", occupancy, 1);
        chk("lit_same_rdy", in_rdy, 1);
        repeat (8) step();

        // Release with nothing loaded sets a sticky flag.
        do_reset(3, 1);
        err_finish = 1'b1; step(); err_finish = 1'b0;
        chk("lit_uf_set", underflow, 1);
        chk("lit_uf_occ", occupancy, 0);
        repeat (3) step();
        chk("lit_uf_sticky", underflow, 1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("lit_uf_flush", underflow, 0);

        // Reset in the middle of a burst discards the partial slot.
        do_reset(3, 1);
        in_vld = 1'b1;
        repeat (2) step();
        reset = 1'b0; in_vld = 1'b0;
        step();
        reset = 1'b1;
        chk("lit_mid_rst_occ", occupancy, 0);
        chk("lit_mid_rst_rdy", in_rdy, 1);
        chk("lit_mid_rst_rd_en", rd_en, 0);
        in_vld = 1'b1;
        #1 chk("lit_mid_rst_wr_addr", wr_addr, 0);
        chk("lit_mid_rst_wr_en", wr_en, 1);
        step();
        in_vld = 1'b0;

        // Random episodes, configuration changed only across reset.
        for (int ep = 0; ep < 8; ep++) begin
            int len, dep;
            len = (ep == 0) ? 0 : (ep == 1) ? 15 : int'($urandom_range(0, 15));
            dep = (ep == 0) ? 0 : (ep == 1) ? 7 : int'($urandom_range(0, 7));
            do_reset(len, dep);
            for (int t = 0; t < 250; t++) begin
                in_vld = ($urandom % 10) < 7;
                if ($urandom % 20 == 0) err_req = ~err_req;
                if (m_occ == 0) err_finish = ($urandom % 40 == 0);
                else err_finish = (m_occ > m_pend) && ($urandom % 12 == 0);
                flush = ($urandom % 150 == 0);
                step();
            end
            flush = 1'b0; err_finish = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
